posit_serial_decoder: RTL and testbench



---
 rtl/posit_serial_decoder.sv | 191 +++++++++++++++++++
 tb/tb_posit_serial_decoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_serial_decoder.sv
`timescale 1ns/1ps
// posit_serial_decoder: splits an N-bit posit into sign, regime k, exponent and
//   hidden-bit mantissa, scanning the regime run one bit per cycle.
// Latency: m+1 SCAN cycles after the accept edge for a regime run of length m
//   (N cycles worst case); Zero/NaR go straight to DONE (valid after the accept edge).
// Backpressure: one word in flight; In_Ready is high only in IDLE, and results
//   are held unchanged in DONE until Out_Ready is seen.
//
// Ports:
//   Clk, Reset           rising-edge clock, asynchronous active-high reset
//   In, In_Valid         posit word and its valid (In sampled on the accept edge only)
//   In_Ready             high in IDLE (also while Reset is asserted)
//   Sign                 posit sign bit
//   RegimeValue          signed regime k, RS+1 bits
//   Exponent             ES-bit exponent, missing low bits read as 0
//   Mantissa             {1'b1, fraction}, fraction truncated / zero-padded
//   Zero, Inf            word was zero / NaR
//   Out_Valid, Out_Ready result handshake

module posit_serial_decoder #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N-1:0]         In,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  output logic                 Sign,
  output logic signed [RS:0]   RegimeValue,
  output logic [ES-1:0]        Exponent,
  output logic [N-ES-3:0]      Mantissa,
  output logic                 Zero,
  output logic                 Inf,
  output logic                 Out_Valid,
  input  logic                 Out_Ready
);

  localparam logic [RS-1:0] REM_INIT = RS'(N - 1);
  localparam logic [RS-1:0] RS_ONE   = RS'(1);
  localparam logic [RS:0]   RV_ONE   = (RS + 1)'(1);
  localparam logic [RS:0]   RV_ZERO  = '0;
  localparam logic [N-1:0]  N_ONE    = N'(1);
  localparam logic [N-1:0]  NAR_WORD = {1'b1, {(N - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Scan datapath: work holds the not-yet-consumed bits left-aligned.
  logic [N-1:0]  work;
  logic          polarity;
  logic [RS-1:0] count;
  logic [RS-1:0] remaining;

  // Accept-side decode
  logic          in_zero;
  logic          in_nar;
  logic [N-1:0]  in_abs;
  logic [N-1:0]  work_init;

  // Scan-side decode
  logic          run_cont;
  logic [N-1:0]  work_shl;
  logic [N-1:0]  work_end;
  logic [RS:0]   count_ext;
  logic [RS:0]   regime_end;
  logic [N-ES:0] mant_wide;

  assign in_zero   = (In == '0);
  assign in_nar    = (In == NAR_WORD);
  assign in_abs    = In[N-1] ? (~In + N_ONE) : In;
  // Drop the sign bit: the regime starts at the new MSB.
  assign work_init = in_abs << 1;

  assign run_cont  = (remaining != '0) && (work[N-1] == polarity);
  assign work_shl  = {work[N-2:0], 1'b0};
  // The terminator bit is only present if the run did not reach the word end.
  assign work_end  = (remaining != '0) ? work_shl : work;

  assign count_ext  = {1'b0, count};
  assign regime_end = polarity ? (count_ext - RV_ONE) : (RV_ZERO - count_ext);

  // Hidden bit in front of everything after the exponent; keep the top MW bits.
  assign mant_wide  = {1'b1, work_end[N-ES-1:0]};

  assign In_Ready  = (state == IDLE);
  assign Out_Valid = (state == DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (In_Valid) begin
          state_next = (in_zero || in_nar) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (!run_cont) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (Out_Ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      work        <= '0;
      polarity    <= 1'b0;
      count       <= '0;
      remaining   <= '0;
      Sign        <= 1'b0;
      RegimeValue <= '0;
      Exponent    <= '0;
      Mantissa    <= '0;
      Zero        <= 1'b0;
      Inf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            if (in_zero || in_nar) begin
              // Special values report only their flag; every other field is 0,
              // including the sign of NaR.
              Sign        <= 1'b0;
              Zero        <= in_zero;
              Inf         <= in_nar;
              RegimeValue <= '0;
              Exponent    <= '0;
              Mantissa    <= '0;
            end else begin
              Sign      <= In[N-1];
              work      <= work_init;
              polarity  <= work_init[N-1];
              count     <= '0;
              remaining <= REM_INIT;
            end
          end
        end
        SCAN: begin
          if (run_cont) begin
            count     <= count + RS_ONE;
            work      <= work_shl;
            remaining <= remaining - RS_ONE;
          end else begin
            work        <= work_end;
            if (remaining != '0) begin
              remaining <= remaining - RS_ONE;
            end
            RegimeValue <= regime_end;
            Exponent    <= work_end[N-1 -: ES];
            Mantissa    <= mant_wide[N-ES:3];
          end
        end
        DONE: begin
          if (Out_Ready) begin
            Zero <= 1'b0;
            Inf  <= 1'b0;
          end
        end
        default: begin
          Zero <= 1'b0;
          Inf  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit_serial_decoder.sv
`timescale 1ns/1ps
module tb_posit_serial_decoder;

  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = $clog2(N);
  localparam int NB = N - 1;        // bits after the sign
  localparam int MW = N - ES - 2;   // mantissa width incl. hidden bit

  logic              Clk;
  logic              Reset;
  logic [N-1:0]      In;
  logic              In_Valid;
  logic              In_Ready;
  logic              Sign;
  logic [RS:0]       RegimeValue;
  logic [ES-1:0]     Exponent;
  logic [MW-1:0]     Mantissa;
  logic              Zero;
  logic              Inf;
  logic              Out_Valid;
  logic              Out_Ready;

  posit_serial_decoder #(.N(N), .ES(ES), .RS(RS)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .In(In),
    .In_Valid(In_Valid),
    .In_Ready(In_Ready),
    .Sign(Sign),
    .RegimeValue(RegimeValue),
    .Exponent(Exponent),
    .Mantissa(Mantissa),
    .Zero(Zero),
    .Inf(Inf),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int sign;
    int rv;
    int ex;
    int mant;
    int zero;
    int inf;
    int lat;
  } exp_t;

  typedef struct {
    logic [N-1:0] w;
    exp_t         e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: read the posit straight from its definition -- run length of
  // identical bits after the sign, skip the terminator, then exponent bits
  // and fraction bits, with missing bits read as zero.
  function automatic exp_t model(input logic [N-1:0] w);
    exp_t e;
    int absv, body, pol, m, consumed, tail, tail_al;
    e = '{default: 0};
    if (w == '0) begin
      e.zero = 1;
      return e;
    end
    if (int'(w) == (1 << (N - 1))) begin
      e.inf = 1;
      return e;
    end
    e.sign = int'(w[N-1]);
    absv = e.sign ? ((1 << N) - int'(w)) : int'(w);
    body = absv & ((1 << NB) - 1);
    pol  = (body >> (NB - 1)) & 1;
    m = 0;
    while (m < NB && (((body >> (NB - 1 - m)) & 1) == pol)) m++;
    consumed = (m < NB) ? m + 1 : m;
    tail     = body & ((1 << (NB - consumed)) - 1);
    tail_al  = (tail << consumed) & ((1 << NB) - 1);
    e.ex   = tail_al >> (NB - ES);
    e.mant = (1 << (MW - 1)) | ((tail_al >> (NB - ES - (MW - 1))) & ((1 << (MW - 1)) - 1));
    e.rv   = pol ? (m - 1) : -m;
    e.lat  = m + 1;
    return e;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] w, input int s, input int rv,
                              input int ex, input int mant, input int z,
                              input int inf, input int lat);
    vec_t v;
    v.w = w;
    v.e.sign = s; v.e.rv = rv; v.e.ex = ex; v.e.mant = mant;
    v.e.zero = z; v.e.inf = inf; v.e.lat = lat;
    return v;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    chk({tag, ".out_valid"}, int'(Out_Valid), 1);
    chk({tag, ".sign"},      int'(Sign), e.sign);
    chk({tag, ".regime"},    int'($signed(RegimeValue)), e.rv);
    chk({tag, ".exponent"},  int'(Exponent), e.ex);
    chk({tag, ".mantissa"},  int'(Mantissa), e.mant);
    chk({tag, ".zero"},      int'(Zero), e.zero);
    chk({tag, ".inf"},       int'(Inf), e.inf);
  endtask

  // Sends one word starting at a falling edge, checks latency, fields,
  // optional hold under backpressure, and the return to IDLE.
  task automatic do_word(input string tag, input logic [N-1:0] w, input exp_t e,
                         input int hold, input bit keep, input logic [N-1:0] nxt);
    int cyc;
    cyc = 0;
    while (!In_Ready && cyc < 50) begin
      @(negedge Clk);
      cyc++;
    end
    chk({tag, ".ready_before"}, int'(In_Ready), 1);
    In        = w;
    In_Valid  = 1'b1;
    Out_Ready = (hold == 0);
    @(negedge Clk);
    chk({tag, ".ready_drop"}, int'(In_Ready), 0);
    In_Valid = keep;
    In       = keep ? nxt : N'($urandom);
    cyc = 0;
    while (!Out_Valid && cyc < 2 * N + 4) begin
      @(negedge Clk);
      cyc++;
    end
    chk({tag, ".latency"}, cyc, e.lat);
    check_fields(tag, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk({tag, ".hold_ready"}, int'(In_Ready), 0);
      check_fields({tag, ".hold"}, e);
      In = N'($urandom);
    end
    Out_Ready = 1'b1;
    @(negedge Clk);
    chk({tag, ".post_valid"}, int'(Out_Valid), 0);
    chk({tag, ".post_ready"}, int'(In_Ready), 1);
    chk({tag, ".post_zero"},  int'(Zero), 0);
    chk({tag, ".post_inf"},   int'(Inf), 0);
  endtask

  vec_t vt[8];

  initial begin
    exp_t e;
    int   pulses;
    logic [N-1:0] w;

    vt[0] = mk(8'h6B, 0,  1, 5, 6, 0, 0, 3);
    vt[1] = mk(8'h95, 1,  1, 5, 6, 0, 0, 3);
    vt[2] = mk(8'h00, 0,  0, 0, 0, 1, 0, 0);
    vt[3] = mk(8'h80, 0,  0, 0, 0, 0, 1, 0);
    vt[4] = mk(8'h7F, 0,  6, 0, 4, 0, 0, 8);
    vt[5] = mk(8'h01, 0, -6, 0, 4, 0, 0, 7);
    vt[6] = mk(8'h40, 0,  0, 0, 4, 0, 0, 2);
    vt[7] = mk(8'h3F, 0, -1, 7, 7, 0, 0, 2);

    Reset     = 1'b1;
    In        = '0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;

    // Reset values, including In_Ready while Reset is held.
    @(negedge Clk);
    chk("rst.in_ready",  int'(In_Ready), 1);
    chk("rst.out_valid", int'(Out_Valid), 0);
    chk("rst.sign",      int'(Sign), 0);
    chk("rst.regime",    int'(RegimeValue), 0);
    chk("rst.exponent",  int'(Exponent), 0);
    chk("rst.mantissa",  int'(Mantissa), 0);
    chk("rst.zero",      int'(Zero), 0);
    chk("rst.inf",       int'(Inf), 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Directed vectors from the table.
    for (int i = 0; i < 8; i++) begin
      do_word($sformatf("vec%0d", i), vt[i].w, vt[i].e, 0, 1'b0, '0);
    end

    // Backpressure: 5 cycles of Out_Ready low.
    do_word("bp", 8'h6B, vt[0].e, 5, 1'b0, '0);

    // In_Valid held high through a DONE handshake with the next word waiting:
    // no accept may happen on the handshake edge, and In changes during SCAN
    // must not disturb the word in flight.
    do_word("chainA", 8'h6B, vt[0].e, 0, 1'b1, 8'h40);
    do_word("chainB", 8'h40, vt[6].e, 0, 1'b0, '0);

    // Reset pulse in the middle of the maxpos scan.
    do_word("pre_rst", 8'h3F, vt[7].e, 0, 1'b0, '0);
    In       = 8'h7F;
    In_Valid = 1'b1;
    @(negedge Clk);
    In_Valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("midscan.out_valid", int'(Out_Valid), 0);
    Reset = 1'b1;
    #1;
    chk("midrst.in_ready",  int'(In_Ready), 1);
    chk("midrst.out_valid", int'(Out_Valid), 0);
    chk("midrst.sign",      int'(Sign), 0);
    chk("midrst.regime",    int'(RegimeValue), 0);
    chk("midrst.exponent",  int'(Exponent), 0);
    chk("midrst.mantissa",  int'(Mantissa), 0);
    chk("midrst.zero",      int'(Zero), 0);
    chk("midrst.inf",       int'(Inf), 0);
    @(negedge Clk);
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Out_Valid) pulses++;
    end
    chk("midrst.no_pulse", pulses, 0);
    do_word("after_rst", 8'h6B, vt[0].e, 0, 1'b0, '0);

    // Random words against the reference model, with random backpressure.
    for (int i = 0; i < 80; i++) begin
      w = N'($urandom);
      e = model(w);
      do_word($sformatf("rnd%0d_%02h", i, w), w, e, $urandom_range(0, 2), 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
